button_debouncer: RTL and testbench



---
 rtl/button_debouncer_pkg.sv | 14 +
 rtl/sync_2ff.sv | 26 ++
 rtl/button_debouncer.sv | 110 +++++++++++
 tb/tb_button_debouncer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared types and constants for the button debouncer
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PENDING,
        PRESSED,
        RELEASE_PENDING
    } dbnc_state_t;

    localparam int DEFAULT_STABLE_CYCLES = 500000;
    localparam int SYNC_STAGES           = 2;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - flop-chain synchroniser for one asynchronous input bit
module sync_2ff
    import button_debouncer_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Reset to the idle pin level so leaving reset never looks like an edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - debounced level plus press/release strobes from a bouncy button
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic rst_async,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    generate
        if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
            $error("button_debouncer: STABLE_CYCLES must be >= 2");
        end
    endgenerate

    logic        w_sync;
    logic        w_s;
    dbnc_state_t r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic        r_level, w_level_nxt;
    logic        r_press, w_press_nxt;
    logic        r_release, w_release_nxt;
    logic        w_last;

    sync_2ff #(
        .RESET_VAL (logic'(ACTIVE_LOW))
    ) u_sync (
        .i_clk (clk),
        .i_rst (rst_async),
        .i_d   (btn_raw),
        .o_q   (w_sync)
    );

    assign w_s    = w_sync ^ ACTIVE_LOW;
    assign w_last = (r_cnt == CNT_W'(STABLE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            RELEASED: begin
                if (w_s) begin
                    w_state_nxt = PRESS_PENDING;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            PRESS_PENDING: begin
                if (!w_s) begin
                    w_state_nxt = RELEASED;
                end else if (w_last) begin
                    w_state_nxt = PRESSED;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!w_s) begin
                    w_state_nxt = RELEASE_PENDING;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            RELEASE_PENDING: begin
                if (w_s) begin
                    w_state_nxt = PRESSED;
                end else if (w_last) begin
                    w_state_nxt   = RELEASED;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = RELEASED;
        endcase
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - randomized and directed checks of button_debouncer against a run-length model
module tb_button_debouncer;

    localparam int STABLE = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_l = 1'b1;
    logic raw_h = 1'b0;
    logic lvl_l, prs_l, rel_l;
    logic lvl_h, prs_h, rel_h;

    always #10 clk = ~clk;

    button_debouncer #(.STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst_async(rst), .btn_raw(raw_l),
        .btn_level(lvl_l), .press_pulse(prs_l), .release_pulse(rel_l)
    );

    button_debouncer #(.STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst_async(rst), .btn_raw(raw_h),
        .btn_level(lvl_h), .press_pulse(prs_h), .release_pulse(rel_h)
    );

    int vectors = 0;
    int errs = 0;

    // Model: raw pin delayed two edges, then a commit once STABLE samples in a row differ from the level
    bit m_pipe0 [2];
    bit m_pipe1 [2];
    bit m_lvl   [2];
    bit m_prs   [2];
    bit m_rel   [2];
    int m_run   [2];
    int last_p  [2];
    int n_prs   [2];
    int n_rel   [2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pipe0[i] = (i == 0);
            m_pipe1[i] = (i == 0);
            m_lvl[i] = 1'b0;
            m_prs[i] = 1'b0;
            m_rel[i] = 1'b0;
            m_run[i] = 0;
            last_p[i] = 2;
            n_prs[i] = 0;
            n_rel[i] = 0;
        end
    endfunction

    function automatic void model_edge(bit rl, bit rh);
        bit s;
        for (int i = 0; i < 2; i++) begin
            s = (i == 0) ? ~m_pipe1[i] : m_pipe1[i];
            m_pipe1[i] = m_pipe0[i];
            m_pipe0[i] = (i == 0) ? rl : rh;
            m_prs[i] = 1'b0;
            m_rel[i] = 1'b0;
            if (s != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == STABLE) begin
                    m_lvl[i] = s;
                    m_prs[i] = s;
                    m_rel[i] = ~s;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic pulse_score(input int i, input logic p, input logic r);
        if (p) begin
            chk(i == 0 ? "alt_press_l" : "alt_press_h", logic'(last_p[i] != 1), 1'b1);
            last_p[i] = 1;
            n_prs[i]++;
        end
        if (r) begin
            chk(i == 0 ? "alt_release_l" : "alt_release_h", logic'(last_p[i] != 2), 1'b1);
            last_p[i] = 2;
            n_rel[i]++;
        end
    endtask

    task automatic check_all();
        chk("level_l", lvl_l, m_lvl[0]);
        chk("press_l", prs_l, m_prs[0]);
        chk("release_l", rel_l, m_rel[0]);
        chk("level_h", lvl_h, m_lvl[1]);
        chk("press_h", prs_h, m_prs[1]);
        chk("release_h", rel_h, m_rel[1]);
        pulse_score(0, prs_l, rel_l);
        pulse_score(1, prs_h, rel_h);
    endtask

    task automatic step();
        bit rl, rh, r;
        rl = raw_l;
        rh = raw_h;
        r  = rst;
        @(posedge clk);
        if (r) model_reset();
        else model_edge(rl, rh);
        #1;
        check_all();
    endtask

    function automatic logic pulse_of(int inst, bit want_press);
        if (inst == 0) return want_press ? prs_l : rel_l;
        return want_press ? prs_h : rel_h;
    endfunction

    task automatic wait_pulse(input string tag, input int inst, input bit want_press, input int exp);
        int n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 40) begin
            step();
            n++;
            hit = pulse_of(inst, want_press);
        end
        vectors++;
        assert (hit && n == exp) else begin
            errs++;
            $error("FAIL %s observed=%0d cycles (hit=%b) expected=%0d cycles", tag, n, hit, exp);
        end
    endtask

    task automatic do_async_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (3) step();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        // 1: reset then idle with the button released
        repeat (3) step();
        rst = 1'b0;
        repeat (50) step();

        // 2: clean press, held
        raw_l = 1'b0;
        wait_pulse("press_latency", 0, 1'b1, 10);
        repeat (101) step();

        // 4: short release glitches, then a clean release
        raw_l = 1'b1; repeat (5) step();
        raw_l = 1'b0; repeat (4) step();
        raw_l = 1'b1; repeat (7) step();
        raw_l = 1'b0; repeat (12) step();
        raw_l = 1'b1;
        wait_pulse("release_latency", 0, 1'b0, 10);
        repeat (20) step();

        // 3: bounce restarts qualification
        raw_l = 1'b0; repeat (5) step();
        raw_l = 1'b1; step();
        raw_l = 1'b0;
        wait_pulse("bounce_press", 0, 1'b1, 10);
        raw_l = 1'b1; repeat (20) step();

        // 5: reset in the middle of a pending press
        raw_l = 1'b0; repeat (6) step();
        do_async_reset();
        wait_pulse("reset_press", 0, 1'b1, 10);
        raw_l = 1'b1; repeat (20) step();

        // 6: active-high instance
        raw_h = 1'b1;
        wait_pulse("hi_press", 1, 1'b1, 10);
        repeat (20) step();
        raw_h = 1'b0;
        wait_pulse("hi_release", 1, 1'b0, 10);
        repeat (5) step();

        // Random segments with occasional asynchronous resets
        for (int seg = 0; seg < 160; seg++) begin
            int len;
            raw_l = 1'($urandom_range(0, 1));
            raw_h = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            repeat (len) step();
            if ($urandom_range(0, 39) == 0) do_async_reset();
        end

        chk("count_balance_l", logic'((n_prs[0] - n_rel[0]) <= 1 && (n_rel[0] - n_prs[0]) <= 1), 1'b1);
        chk("count_balance_h", logic'((n_prs[1] - n_rel[1]) <= 1 && (n_rel[1] - n_prs[1]) <= 1), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
